// File: rtl/if_fetch_stage_pkg.sv
// Shared widths, bus payloads and state encodings for the instruction-fetch stage.
package if_fetch_stage_pkg;

    localparam int unsigned IF_TO_ID_WD  = 33;
    localparam int unsigned BR_WD        = 33;
    localparam int unsigned STALL_BUS_WD = 6;
    localparam int unsigned ADDR_WD      = 32;
    localparam int unsigned INST_WD      = 32;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [ADDR_WD-1:0] IF_RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DATA = 2'd2,
        S_HOLD = 2'd3
    } if_state_e;

    typedef struct packed {
        logic               br_e;
        logic [ADDR_WD-1:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic               ce;
        logic [ADDR_WD-1:0] pc;
    } if_to_id_t;

endpackage

// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns the PC, runs one request at a time on the inst SRAM
// interface and hands {ce, pc} plus the instruction to decode.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [ADDR_WD-1:0] RESET_PC = IF_RESET_PC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS_WD-1:0] stall,
    input  logic [BR_WD-1:0]        br_bus,
    output logic                    stallreq_if,
    output logic [IF_TO_ID_WD-1:0]  if_to_id_bus,
    output logic [INST_WD-1:0]      if_inst,
    output logic                    if_adel,
    output logic                    inst_sram_req,
    output logic [ADDR_WD-1:0]      inst_sram_addr,
    input  logic                    inst_sram_addr_ok,
    input  logic                    inst_sram_data_ok,
    input  logic [INST_WD-1:0]      inst_sram_rdata
);

    if_state_e          state;
    if_state_e          state_nxt;
    br_bus_t            br;
    if_to_id_t          id_bus;
    logic [ADDR_WD-1:0] pc;
    logic [ADDR_WD-1:0] next_pc;
    logic [ADDR_WD-1:0] redirect_addr;
    logic               redirect_valid;
    logic [INST_WD-1:0] inst_buf;
    logic               adel_r;
    logic               misaligned;
    logic               advance;

    // Only the IF hold bit of the controller vector matters here.
    logic unused_stall;
    assign unused_stall = ^stall[STALL_BUS_WD-1:1];

    assign br         = br_bus_t'(br_bus);
    assign misaligned = (pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nxt      = state;
        inst_sram_req  = 1'b0;
        stallreq_if    = NO_STOP;
        advance        = 1'b0;
        id_bus.ce      = 1'b0;
        id_bus.pc      = pc;
        if_inst        = '0;
        if_adel        = 1'b0;
        inst_sram_addr = pc;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                stallreq_if = STOP;
                if (misaligned) begin
                    state_nxt = S_HOLD;
                end else begin
                    inst_sram_req = 1'b1;
                    if (inst_sram_addr_ok) state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                stallreq_if = STOP;
                if (inst_sram_data_ok) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                id_bus.ce = 1'b1;
                if_inst   = inst_buf;
                if_adel   = adel_r;
                if (stall[0] == NO_STOP) begin
                    advance   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign if_to_id_bus = id_bus;

    // A branch seen this cycle wins over one buffered during an earlier stall.
    always_comb begin
        next_pc = pc + 32'd4;
        if (br.br_e) begin
            next_pc = br.br_addr;
        end else if (redirect_valid) begin
            next_pc = redirect_addr;
        end
    end

    // PC, fetched word and redirect buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc             <= RESET_PC;
            inst_buf       <= '0;
            adel_r         <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_addr  <= '0;
        end else begin
            if (state == S_REQ && misaligned) begin
                inst_buf <= '0;
                adel_r   <= 1'b1;
            end else if (state == S_DATA && inst_sram_data_ok) begin
                inst_buf <= inst_sram_rdata;
            end
            if (advance) begin
                pc             <= next_pc;
                adel_r         <= 1'b0;
                redirect_valid <= 1'b0;
            end else if (br.br_e) begin
                redirect_valid <= 1'b1;
                redirect_addr  <= br.br_addr;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: SRAM responder with programmable waits and
// a queue of expected deliveries checked whenever ce rises.
module tb_if_fetch_stage;
    import if_fetch_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [32:0] br_bus;
    logic        stallreq_if;
    logic [32:0] if_to_id_bus;
    logic [31:0] if_inst;
    logic        if_adel;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    if_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .br_bus            (br_bus),
        .stallreq_if       (stallreq_if),
        .if_to_id_bus      (if_to_id_bus),
        .if_inst           (if_inst),
        .if_adel           (if_adel),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          errors  = 0;
    int          n_del   = 0;
    int          cyc     = 0;
    int          addr_dly = 0;
    int          data_dly = 0;
    bit          inject_stray = 0;
    bit          pend = 0;
    int          acnt = 0;
    int          dcnt = 0;
    logic [31:0] paddr;
    logic        ce_prev = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic adel);
        exp_t e;
        e.pc   = pc;
        e.inst = adel ? 32'h0 : mem_word(pc);
        e.adel = adel;
        exp_q.push_back(e);
    endtask

    // SRAM model: addr_ok after addr_dly waiting cycles, data_ok data_dly cycles later.
    always @(posedge clk) begin
        #1;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        if (rst) begin
            pend = 0;
            acnt = 0;
            dcnt = 0;
        end else if (pend) begin
            if (dcnt >= data_dly) begin
                inst_sram_data_ok = 1'b1;
                inst_sram_rdata   = mem_word(paddr);
                pend = 0;
            end else begin
                dcnt++;
            end
        end else if (inst_sram_req) begin
            check32("req_addr", inst_sram_addr, (exp_q.size() != 0) ? exp_q[0].pc : 32'hFFFF_FFFF);
            if (acnt >= addr_dly) begin
                inst_sram_addr_ok = 1'b1;
                pend  = 1;
                paddr = inst_sram_addr;
                dcnt  = 0;
                acnt  = 0;
            end else begin
                acnt++;
                if (inject_stray) begin
                    inst_sram_data_ok = 1'b1;
                    inst_sram_rdata   = 32'hDEAD_BEEF;
                end
            end
        end
    end

    // Delivery monitor: each rising ce consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        check1("req_aligned", inst_sram_req & (inst_sram_addr[1:0] != 2'b00), 1'b0);
        if (!if_to_id_bus[32]) begin
            check32("bubble_inst", if_inst, 32'h0);
            check1("bubble_adel", if_adel, 1'b0);
        end else if (!ce_prev) begin
            n_del++;
            vectors++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL delivery_extra got=%h exp=none", if_to_id_bus[31:0]);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check32("deliver_pc", if_to_id_bus[31:0], e.pc);
                check32("deliver_inst", if_inst, e.inst);
                check1("deliver_adel", if_adel, e.adel);
            end
        end
        ce_prev = if_to_id_bus[32];
    end

    task automatic wait_deliver(input int target, input bit chk_stall);
        for (int k = 0; k < 60; k++) begin
            if (n_del >= target) break;
            if (chk_stall) check1("stallreq_busy", stallreq_if, STOP);
            @(negedge clk); #1;
        end
        vectors++;
        assert (n_del >= target) else begin
            errors++;
            $error("FAIL deliver_timeout got=%0d exp=%0d", n_del, target);
        end
    endtask

    // Release the IF hold for exactly one cycle, optionally with a branch.
    task automatic step(input bit be, input logic [31:0] ba);
        @(posedge clk); #2;
        stall[0] = 1'b0;
        br_bus   = {be, ba};
        @(posedge clk); #2;
        stall[0] = 1'b1;
        br_bus   = '0;
    endtask

    task automatic pulse_br(input logic [31:0] ba);
        br_bus = {1'b1, ba};
        @(posedge clk); #2;
        br_bus = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t_req;
        int nd;
        rst = 1'b1;
        stall = 6'b000001;
        br_bus = '0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata = '0;
        t_req = 0;
        nd = 0;

        // Reset outputs.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check1("rst_req", inst_sram_req, 1'b0);
        check1("rst_ce", if_to_id_bus[32], 1'b0);
        check32("rst_inst", if_inst, 32'h0);
        check1("rst_adel", if_adel, 1'b0);
        check1("rst_stallreq", stallreq_if, NO_STOP);

        // Zero-wait SRAM: first fetch from the reset vector, 2-cycle req-to-ce.
        push_exp(RST_PC, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk); #1;
        check1("idle_req", inst_sram_req, 1'b0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (inst_sram_req) break;
        end
        t_req = cyc;
        nd++; wait_deliver(nd, 1'b1);
        check32("first_latency", 32'(cyc - t_req), 32'd2);
        check1("hold_stallreq", stallreq_if, NO_STOP);
        push_exp(32'hBFC0_0004, 1'b0);
        step(1'b0, 32'h0);
        nd++; wait_deliver(nd, 1'b1);

        // Slow SRAM: req held with stable address, Stop throughout.
        addr_dly = 3; data_dly = 2;
        push_exp(32'hBFC0_0008, 1'b0);
        step(1'b0, 32'h0);
        nd++; wait_deliver(nd, 1'b1);
        addr_dly = 0; data_dly = 0;

        // Branch while the delay slot is being fetched: slot delivered, then target.
        push_exp(32'hBFC0_000C, 1'b0);
        push_exp(32'hBFC0_0100, 1'b0);
        step(1'b0, 32'h0);
        pulse_br(32'hBFC0_0100);
        nd++; wait_deliver(nd, 1'b1);
        step(1'b0, 32'h0);
        nd++; wait_deliver(nd, 1'b1);

        // Branch in the advancing cycle goes straight to pc, nothing buffered.
        push_exp(32'hBFC0_0200, 1'b0);
        step(1'b1, 32'hBFC0_0200);
        nd++; wait_deliver(nd, 1'b1);
        push_exp(32'hBFC0_0204, 1'b0);
        step(1'b0, 32'h0);
        nd++; wait_deliver(nd, 1'b1);

        // Branch during S_DATA, then 4 held cycles, then buffered target.
        data_dly = 2;
        push_exp(32'hBFC0_0208, 1'b0);
        step(1'b0, 32'h0);
        @(posedge clk); #2;
        pulse_br(32'hBFC0_0300);
        nd++; wait_deliver(nd, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check1("stall_ce", if_to_id_bus[32], 1'b1);
            check32("stall_pc", if_to_id_bus[31:0], 32'hBFC0_0208);
            check32("stall_inst", if_inst, mem_word(32'hBFC0_0208));
            check1("stall_stallreq", stallreq_if, NO_STOP);
        end
        data_dly = 0;
        push_exp(32'hBFC0_0300, 1'b0);
        step(1'b0, 32'h0);
        nd++; wait_deliver(nd, 1'b1);

        // Misaligned target: no request, adel with zero instruction, pc+4 follows.
        push_exp(32'hBFC0_0002, 1'b1);
        step(1'b1, 32'hBFC0_0002);
        nd++; wait_deliver(nd, 1'b1);
        push_exp(32'hBFC0_0006, 1'b1);
        step(1'b0, 32'h0);
        nd++; wait_deliver(nd, 1'b1);
        push_exp(32'hBFC0_0400, 1'b0);
        step(1'b1, 32'hBFC0_0400);
        nd++; wait_deliver(nd, 1'b1);

        // Reset during S_DATA abandons the fetch; stray data_ok in S_REQ ignored.
        data_dly = 5;
        push_exp(32'hBFC0_0404, 1'b0);
        step(1'b0, 32'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk); #1;
        check1("midrst_req", inst_sram_req, 1'b0);
        check1("midrst_ce", if_to_id_bus[32], 1'b0);
        check1("midrst_stallreq", stallreq_if, NO_STOP);
        addr_dly = 2; data_dly = 0; inject_stray = 1;
        push_exp(RST_PC, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        nd++; wait_deliver(nd, 1'b0);
        inject_stray = 0;

        vectors++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL leftover_expected got=%0d exp=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage: owns the PC, issues requests on a req/addr_ok/data_ok instruction SRAM interface, and presents {ce, pc} plus the fetched instruction to the decode stage.
- Acts on the branch bus {br_e, br_addr} from decode. Honours the MIPS single delay slot.
- Raises a stall request to the pipeline controller while a fetch is incomplete.

Parameters:
- RESET_PC, 32'hBFC0_0000, address of the first fetch after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  `StallBus (6)  controller stall vector; bit0 = IF hold
- br_bus  in  `BR_WD (33)  {br_e, br_addr[31:0]} from decode, combinational
- stallreq_if  out  1  fetch not complete; `Stop/`NoStop encoding
- if_to_id_bus  out  `IF_TO_ID_WD (33)  {ce, pc[31:0]}
- if_inst  out  32  instruction word aligned with if_to_id_bus
- if_adel  out  1  pc misaligned (pc[1:0]!=0); instruction forced to 0
- inst_sram_req  out  1  request valid
- inst_sram_addr  out  32  request address (= pc)
- inst_sram_addr_ok  in  1  request accepted this cycle
- inst_sram_data_ok  in  1  read data valid this cycle
- inst_sram_rdata  in  32  read data

Behaviour:
- Reset state: S_IDLE, pc=RESET_PC. No redirect pending.
- Outputs during and after reset: req=0, ce=0, if_inst=0, if_adel=0, stallreq_if=`NoStop.
- Leaving reset: S_IDLE -> S_REQ on the first cycle rst=0.
- S_REQ:
  - req=1, addr=pc, stallreq_if=`Stop.
  - addr_ok=1 -> S_DATA.
  - If pc[1:0]!=0: req=0 and go directly to S_HOLD with inst_buf=0 and adel_r=1.
- S_DATA:
  - req=0, stallreq_if=`Stop.
  - data_ok=1 -> capture rdata into inst_buf and go to S_HOLD.
  - Only one request outstanding at a time. data_ok outside S_DATA is ignored.
- S_HOLD:
  - ce=1, if_to_id_bus={1,pc}, if_inst=inst_buf, stallreq_if=`NoStop.
  - When stall[0]==`NoStop: pc<=next_pc, adel_r<=0, go to S_REQ. The next request issues the following cycle.
  - When stall[0]==`Stop: hold pc, inst_buf and state.
- ce and if_inst in other states: ce=0 and if_inst=0 (bubble) in every state except S_HOLD.
- next_pc priority:
  - br_e this cycle -> br_addr;
  - else redirect_valid -> redirect_addr;
  - else pc+4, with 32-bit wrap (32'hFFFF_FFFC+4 = 0).
- Redirect buffer:
  - br_e=1 in any cycle that does not advance pc: redirect_valid<=1, redirect_addr<=br_addr. A later br_e overwrites it.
  - Cleared on the cycle pc advances.
  - br_e and advance in the same cycle: br_addr is used directly and nothing is buffered.
- Delay slot: the instruction held or being fetched when br_e arrives is the delay slot. It is never squashed; the redirect applies to the advance after it.
- Stall interaction: stall[0] does not abort an in-flight request. S_REQ and S_DATA proceed regardless of stall; only the advance out of S_HOLD is gated.
- Mid-operation reset: immediate return to S_IDLE; outstanding request abandoned. The SRAM is reset on the same rst, so no late data_ok is expected.
- Latency: minimum 3 cycles per instruction (S_REQ, S_DATA, S_HOLD) with addr_ok and data_ok each arriving in 1 cycle.

Decomposition:
- Add to lib/defines.vh:
  - IF_TO_ID_WD=33, BR_WD=33, StallBus=6, Stop/NoStop (existing);
  - IF_RESET_PC;
  - IF state encodings S_IDLE/S_REQ/S_DATA/S_HOLD (2 bits).
- No sub-module. PC, FSM and redirect buffer stay in one module (~150-200 lines).

Test Plan:
- Reset, zero-wait SRAM (addr_ok same cycle as req, data_ok next cycle):
  - first req addr=32'hBFC0_0000;
  - if_to_id_bus={1,BFC0_0000} two cycles after req;
  - next req addr=32'hBFC0_0004.
- SRAM addr_ok delayed 3 cycles and data_ok delayed 2: req held high with a stable addr; stallreq_if=`Stop throughout; ce=0 until data_ok; if_inst equals rdata.
- Branch, no stall: br_e=1, br_addr=32'hBFC0_0100 pulsed while IF fetches delay slot 0xBFC0_0008 -> 0x8 is delivered with ce=1; next req addr=0xBFC0_0100.
- Branch during stall: br_e pulsed for 1 cycle while in S_DATA, then stall[0]=`Stop for 4 cycles in S_HOLD -> pc, if_inst and bus held; on release the next req addr equals the buffered br_addr.
- Misaligned jump: br_addr=32'hBFC0_0002 -> no inst_sram_req for that pc; if_adel=1, if_inst=0, ce=1 in S_HOLD; next pc=32'hBFC0_0006.
- Reset asserted while in S_DATA: req=0, ce=0 next cycle; first req after rst release addr=RESET_PC; a stray data_ok during S_REQ is ignored.
